// File: rtl/jesd204_rx_ilas_cfg_check.sv
// -----------------------------------------------------------------------------
// jesd204_rx_ilas_cfg_check
//
// Per-lane JESD204 RX ILAS configuration checker. It consumes the ILAS config
// beat stream from the RX lane block (four octets per beat, beat index on addr).
// It assembles the 14-octet link configuration and verifies the FCHK checksum.
// It also compares the decoded L, F*K and LID against the programmed link
// configuration.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   ilas_config_valid/addr/data beat strobe, beat index, octets 4*addr+i on
//                               data[8i+7:8i]
//   cfg_*                       programmed link configuration (quasi-static)
//   ctrl_clear                  clears sticky flags and the error counter
//   ilas_cfg_done               a complete, checked configuration is held
//   ilas_lid/l_m1/f_m1/k_m1     decoded fields, updated once per check
//   status_*                    sticky check / sequence error flags
//   status_ilas_err_cnt         saturating count of errored captures
//
// Optional feature:
//   JESD204_ILAS_CFG_RAW_OUT_EN adds ilas_cfg_raw[111:0] = {o13..o0}. It is
//   updated together with the decoded fields.
// -----------------------------------------------------------------------------
module jesd204_rx_ilas_cfg_check #(
   parameter int DATA_PATH_WIDTH = 4,
   parameter int ERR_CNT_WIDTH   = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     ilas_config_valid,
   input  logic [1:0]               ilas_config_addr,
   input  logic [31:0]              ilas_config_data,
   input  logic [4:0]               cfg_lanes_per_link,
   input  logic [4:0]               cfg_lid,
   input  logic [7:0]               cfg_octets_per_frame,
   input  logic [9:0]               cfg_octets_per_multiframe,
   input  logic                     ctrl_clear,
   output logic                     ilas_cfg_done,
   output logic [4:0]               ilas_lid,
   output logic [4:0]               ilas_l_m1,
   output logic [7:0]               ilas_f_m1,
   output logic [4:0]               ilas_k_m1,
   output logic                     status_checksum_err,
   output logic                     status_lid_mismatch,
   output logic                     status_l_mismatch,
   output logic                     status_fk_mismatch,
   output logic                     status_seq_err,
   output logic [ERR_CNT_WIDTH-1:0] status_ilas_err_cnt
`ifdef JESD204_ILAS_CFG_RAW_OUT_EN
   ,
   output logic [111:0]             ilas_cfg_raw
`endif
);

   if (DATA_PATH_WIDTH != 4) begin : g_dpw_check
      $error("jesd204_rx_ilas_cfg_check: DATA_PATH_WIDTH must be 4");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_CHECK   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Sum of the ILAS field values (not raw octets) carried by one beat, mod 256.
   // Reserved octets, FCHK and the ignored o14/o15 contribute nothing.
   function automatic logic [7:0] beat_field_sum(input logic [1:0]  addr,
                                                 input logic [31:0] d);
      logic [7:0] b0, b1, b2, b3;
      logic [7:0] s;
      b0 = d[7:0];
      b1 = d[15:8];
      b2 = d[23:16];
      b3 = d[31:24];
      case (addr)
         // DID, ADJCNT, BID, ADJDIR, PHADJ, LID, SCR, L-1
         2'd0: s = b0 + 8'(b1[7:4]) + 8'(b1[3:0]) + 8'(b2[6]) + 8'(b2[5])
                   + 8'(b2[4:0]) + 8'(b3[7]) + 8'(b3[4:0]);
         // F-1, K-1, M-1, CS, N-1
         2'd1: s = b0 + 8'(b1[4:0]) + b2 + 8'(b3[7:6]) + 8'(b3[4:0]);
         // SUBCLASSV, NP-1, JESDV, S-1, HD, CF (o11 is reserved)
         2'd2: s = 8'(b0[7:5]) + 8'(b0[4:0]) + 8'(b1[7:5]) + 8'(b1[4:0])
                   + 8'(b2[7]) + 8'(b2[4:0]) + 8'(b3 & 8'h00);
         default: s = 8'd0;
      endcase
      return s;
   endfunction

   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + ERR_CNT_WIDTH'(1);
   endfunction

   state_t                   state_q;
   logic [1:0]               exp_addr_q;
   logic                     done_q;
   logic [7:0]               cap_sum_q;
   logic [7:0]               cap_fchk_q;
   logic [4:0]               cap_lid_q;
   logic [4:0]               cap_l_q;
   logic [7:0]               cap_f_q;
   logic [4:0]               cap_k_q;
   logic [4:0]               lid_q;
   logic [4:0]               l_q;
   logic [7:0]               f_q;
   logic [4:0]               k_q;
   logic                     csum_err_q, lid_mm_q, l_mm_q, fk_mm_q, seq_err_q;
   logic                     csum_err_d, lid_mm_d, l_mm_d, fk_mm_d, seq_err_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, err_cnt_base;
`ifdef JESD204_ILAS_CFG_RAW_OUT_EN
   logic [111:0]             raw_cap_q;
   logic [111:0]             raw_q;
`endif

   logic        chk;
   logic        csum_set, lid_set, l_set, fk_set, seq_set, any_err;
   logic        store_beat;
   logic [7:0]  beat_sum;
   logic [12:0] fk_m1;

   // F is only checked through the F*K product against the multiframe length.
   logic unused_cfg_f;
   assign unused_cfg_f = ^cfg_octets_per_frame;

   assign beat_sum = beat_field_sum(ilas_config_addr, ilas_config_data);
   assign fk_m1    = 13'((13'(cap_f_q) + 13'd1) * (13'(cap_k_q) + 13'd1) - 13'd1);

   always_comb begin
      chk      = (state_q == ST_CHECK);
      csum_set = chk && (cap_sum_q != cap_fchk_q);
      lid_set  = chk && (cap_lid_q != cfg_lid);
      l_set    = chk && (cap_l_q != cfg_lanes_per_link);
      fk_set   = chk && (fk_m1 != {3'b000, cfg_octets_per_multiframe});
      any_err  = csum_set || lid_set || l_set || fk_set;
      // An addr=0 beat restarts cleanly in any state that accepts beats.
      seq_set  = ilas_config_valid && (ilas_config_addr != 2'd0) &&
                 ((state_q == ST_IDLE) ||
                  ((state_q == ST_CAPTURE) && (ilas_config_addr != exp_addr_q)));
      store_beat = ilas_config_valid &&
                   ((ilas_config_addr == 2'd0) ? (state_q != ST_CHECK)
                                               : ((state_q == ST_CAPTURE) &&
                                                  (ilas_config_addr == exp_addr_q)));

      // A set event in the same cycle as ctrl_clear wins.
      csum_err_d = csum_set || (csum_err_q && !ctrl_clear);
      lid_mm_d   = lid_set  || (lid_mm_q   && !ctrl_clear);
      l_mm_d     = l_set    || (l_mm_q     && !ctrl_clear);
      fk_mm_d    = fk_set   || (fk_mm_q    && !ctrl_clear);
      seq_err_d  = seq_set  || (seq_err_q  && !ctrl_clear);

      err_cnt_base = ctrl_clear ? '0 : err_cnt_q;
      err_cnt_d    = any_err ? sat_inc(err_cnt_base) : err_cnt_base;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         exp_addr_q <= 2'd0;
         done_q     <= 1'b0;
         cap_sum_q  <= 8'd0;
         cap_fchk_q <= 8'd0;
         cap_lid_q  <= 5'd0;
         cap_l_q    <= 5'd0;
         cap_f_q    <= 8'd0;
         cap_k_q    <= 5'd0;
         lid_q      <= 5'd0;
         l_q        <= 5'd0;
         f_q        <= 8'd0;
         k_q        <= 5'd0;
         csum_err_q <= 1'b0;
         lid_mm_q   <= 1'b0;
         l_mm_q     <= 1'b0;
         fk_mm_q    <= 1'b0;
         seq_err_q  <= 1'b0;
         err_cnt_q  <= '0;
`ifdef JESD204_ILAS_CFG_RAW_OUT_EN
         raw_cap_q  <= '0;
         raw_q      <= '0;
`endif
      end else begin
         csum_err_q <= csum_err_d;
         lid_mm_q   <= lid_mm_d;
         l_mm_q     <= l_mm_d;
         fk_mm_q    <= fk_mm_d;
         seq_err_q  <= seq_err_d;
         err_cnt_q  <= err_cnt_d;

         // Capture: the running field sum restarts on every addr=0 beat.
         if (store_beat) begin
            case (ilas_config_addr)
               2'd0: begin
                  cap_sum_q <= beat_sum;
                  cap_lid_q <= ilas_config_data[20:16];
                  cap_l_q   <= ilas_config_data[28:24];
               end
               2'd1: begin
                  cap_sum_q <= cap_sum_q + beat_sum;
                  cap_f_q   <= ilas_config_data[7:0];
                  cap_k_q   <= ilas_config_data[12:8];
               end
               2'd2: cap_sum_q <= cap_sum_q + beat_sum;
               default: cap_fchk_q <= ilas_config_data[15:8];
            endcase
`ifdef JESD204_ILAS_CFG_RAW_OUT_EN
            case (ilas_config_addr)
               2'd0: raw_cap_q[31:0]   <= ilas_config_data;
               2'd1: raw_cap_q[63:32]  <= ilas_config_data;
               2'd2: raw_cap_q[95:64]  <= ilas_config_data;
               default: raw_cap_q[111:96] <= ilas_config_data[15:0];
            endcase
`endif
         end

         case (state_q)
            ST_IDLE: begin
               if (ilas_config_valid && (ilas_config_addr == 2'd0)) begin
                  exp_addr_q <= 2'd1;
                  done_q     <= 1'b0;
                  state_q    <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (ilas_config_valid) begin
                  if (ilas_config_addr == exp_addr_q) begin
                     if (ilas_config_addr == 2'd3) begin
                        state_q <= ST_CHECK;
                     end else begin
                        exp_addr_q <= exp_addr_q + 2'd1;
                     end
                  end else if (ilas_config_addr == 2'd0) begin
                     exp_addr_q <= 2'd1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_CHECK: begin
               lid_q   <= cap_lid_q;
               l_q     <= cap_l_q;
               f_q     <= cap_f_q;
               k_q     <= cap_k_q;
               done_q  <= 1'b1;
`ifdef JESD204_ILAS_CFG_RAW_OUT_EN
               raw_q   <= raw_cap_q;
`endif
               state_q <= ST_DONE;
            end
            default: begin
               if (ilas_config_valid && (ilas_config_addr == 2'd0)) begin
                  exp_addr_q <= 2'd1;
                  done_q     <= 1'b0;
                  state_q    <= ST_CAPTURE;
               end
            end
         endcase
      end
   end

   assign ilas_cfg_done       = done_q;
   assign ilas_lid            = lid_q;
   assign ilas_l_m1           = l_q;
   assign ilas_f_m1           = f_q;
   assign ilas_k_m1           = k_q;
   assign status_checksum_err = csum_err_q;
   assign status_lid_mismatch = lid_mm_q;
   assign status_l_mismatch   = l_mm_q;
   assign status_fk_mismatch  = fk_mm_q;
   assign status_seq_err      = seq_err_q;
   assign status_ilas_err_cnt = err_cnt_q;
`ifdef JESD204_ILAS_CFG_RAW_OUT_EN
   assign ilas_cfg_raw        = raw_q;
`endif

endmodule
